// File: rtl/subtractor_pipe_pkg.sv
// Shared widths and result bundle for the pipelined subtractor.
// The bundle type is sized for the default width.
package subtractor_pipe_pkg;

    localparam int SUB_WIDTH  = 8;
    localparam int SUB_DWIDTH = SUB_WIDTH + 1;

    typedef struct packed {
        logic [SUB_DWIDTH-1:0] diff;
        logic                  borrow;
        logic                  diff_zero;
    } sub_res_t;

    // Result width for an arbitrary operand width: difference plus borrow/sign bit.
    function automatic int sub_dwidth(input int w);
        return w + 1;
    endfunction

endpackage

// File: rtl/subtractor_pipe_pipe_reg.sv
// Single valid/ready register slice; accepts a new beat whenever it is empty
// or its current beat is being popped in the same cycle.
module pipe_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_valid && in_ready) begin
            out_valid <= 1'b1;
            out_data  <= in_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/subtractor_pipe.sv
// Two-stage valid/ready subtractor: S1 holds operands, S2 holds the
// registered difference with borrow and zero flags.
module subtractor_pipe
    import subtractor_pipe_pkg::*;
#(
    parameter int WIDTH  = SUB_WIDTH,
    parameter int DWIDTH = WIDTH + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  x,
    input  logic [WIDTH-1:0]  y,
    input  logic              bin,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] diff,
    output logic              borrow,
    output logic              diff_zero
);

    typedef struct packed {
        logic             bin;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] x;
    } opnd_t;

    typedef struct packed {
        logic [DWIDTH-1:0] diff;
        logic              borrow;
        logic              diff_zero;
    } res_t;

    opnd_t s1_in, s1_q;
    res_t  s2_in, s2_q;
    logic  s1_valid, s2_ready;
    logic  [DWIDTH-1:0] x_ext, y_ext, d;

    assign s1_in = '{bin: bin, y: y, x: x};

    pipe_reg #(.DATA_W($bits(opnd_t))) u_s1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (s1_in),
        .out_valid (s1_valid),
        .out_ready (s2_ready),
        .out_data  (s1_q)
    );

    // Zero-extension keeps the worst case 0 - max - 1 representable.
    assign x_ext = DWIDTH'(s1_q.x);
    assign y_ext = DWIDTH'(s1_q.y);
    assign d     = x_ext - y_ext - DWIDTH'(s1_q.bin);

    assign s2_in = '{diff: d, borrow: d[DWIDTH-1], diff_zero: (d == '0)};

    pipe_reg #(.DATA_W($bits(res_t))) u_s2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_ready  (s2_ready),
        .in_data   (s2_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (s2_q)
    );

    assign diff      = s2_q.diff;
    assign borrow    = s2_q.borrow;
    assign diff_zero = s2_q.diff_zero;

endmodule

// File: tb/tb_subtractor_pipe.sv
// Directed bench for subtractor_pipe: latency, arithmetic corners,
// backpressure, full-rate streaming and asynchronous reset.
module tb_subtractor_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] x;
    logic [7:0] y;
    logic       bin;
    logic       out_valid;
    logic       out_ready;
    logic [8:0] diff;
    logic       borrow;
    logic       diff_zero;

    int n_cmp = 0;
    int n_err = 0;

    subtractor_pipe #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .y         (y),
        .bin       (bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .diff_zero (diff_zero)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] xa, input logic [7:0] ya, input logic b);
        in_valid = v;
        x        = xa;
        y        = ya;
        bin      = b;
    endtask

    task automatic check_out(input string tag, input logic [8:0] d, input logic b, input logic z);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_diff"}, 32'(diff), 32'(d));
        check({tag, "_borrow"}, 32'(borrow), 32'(b));
        check({tag, "_zero"}, 32'(diff_zero), 32'(z));
    endtask

    initial begin
        logic [8:0] e;
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_zero", 32'(diff_zero), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", 32'(in_ready), 32'd1);

        // basic: 200 - 55 = 145, two cycles after accept
        drive(1'b1, 8'd200, 8'd55, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        check("basic_lat1_valid", 32'(out_valid), 32'd0);
        tick();
        check_out("basic", 9'h091, 1'b0, 1'b0);
        tick();
        check("basic_drain", 32'(out_valid), 32'd0);

        // worst-case negative with borrow-in, then exact zero
        drive(1'b1, 8'd0, 8'd255, 1'b1);
        tick();
        drive(1'b1, 8'd10, 8'd10, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        check_out("neg", 9'h100, 1'b1, 1'b0);
        tick();
        check_out("zero", 9'h000, 1'b0, 1'b1);
        tick();
        check("neg_drain", 32'(out_valid), 32'd0);

        // backpressure: capacity two, then in-order drain with no gaps
        out_ready = 1'b0;
        drive(1'b1, 8'd1, 8'd0, 1'b0);
        check("bp_rdy0", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 8'd2, 8'd0, 1'b0);
        check("bp_rdy1", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 8'd3, 8'd0, 1'b0);
        check("bp_full_rdy", 32'(in_ready), 32'd0);
        check_out("bp_hold0", 9'd1, 1'b0, 1'b0);
        tick();
        check("bp_full_rdy2", 32'(in_ready), 32'd0);
        check_out("bp_hold1", 9'd1, 1'b0, 1'b0);
        tick();
        check_out("bp_hold2", 9'd1, 1'b0, 1'b0);
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        tick();
        drive(1'b1, 8'd4, 8'd0, 1'b0);
        check_out("bp_out2", 9'd2, 1'b0, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        check_out("bp_out3", 9'd3, 1'b0, 1'b0);
        tick();
        check_out("bp_out4", 9'd4, 1'b0, 1'b0);
        tick();
        check("bp_drain", 32'(out_valid), 32'd0);

        // full throughput: 16 back-to-back beats
        for (int c = 0; c < 18; c++) begin
            if (c < 16) drive(1'b1, 8'(c), 8'(c / 2), 1'(c % 2));
            else        drive(1'b0, 8'd0, 8'd0, 1'b0);
            tick();
            if (c >= 1 && c <= 16) begin
                e = 9'((c - 1) - (c - 1) / 2 - (c - 1) % 2);
                check_out($sformatf("tp%0d", c - 1), e, e[8], e == 9'd0);
            end else begin
                check($sformatf("tp_idle%0d", c), 32'(out_valid), 32'd0);
            end
        end

        // asynchronous reset with two beats in flight
        drive(1'b1, 8'd5, 8'd1, 1'b0);
        tick();
        drive(1'b1, 8'd6, 8'd1, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        check_out("pre_rst", 9'd4, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid), 32'd0);
        check("arst_diff", 32'(diff), 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        tick();
        check("arst_no_stale0", 32'(out_valid), 32'd0);
        drive(1'b1, 8'd7, 8'd3, 1'b0);
        tick();
        drive(1'b0, 8'd0, 8'd0, 1'b0);
        check("arst_no_stale1", 32'(out_valid), 32'd0);
        tick();
        check_out("post_rst", 9'd4, 1'b0, 1'b0);
        tick();
        check("post_rst_drain", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
